sprite_load_ctrl: RTL and testbench



---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_load_ctrl_if.sv | 34 +++
 rtl/byte_fifo.sv | 48 ++++
 rtl/sprite_load_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sprite_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite load controller.
//   Command opcodes received over SPI, bitmap payload length,
//   controller FSM states and the 6-bit colour type.
package sprite_pkg;

  typedef logic [5:0] color_t;
  typedef logic [7:0] byte_t;

  localparam byte_t CMD_BITMAP = 8'h01;
  localparam byte_t CMD_FG     = 8'h02;
  localparam byte_t CMD_BG     = 8'h03;
  localparam byte_t CMD_CLR    = 8'h04;

  // 100 bitmap bits packed MSB-first; last byte carries only 4 valid bits
  localparam int unsigned BITMAP_BYTES = 13;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    DRAIN
  } state_t;

endpackage

// File: rtl/sprite_load_ctrl_if.sv
// Pin bundle of the sprite load controller.
//   Inputs : SPI pins (spi_clk, spi_data, spi_sel_n), vblank, display_shift
//   Outputs: sprite register controls (sprite_shift, sprite_load, sprite_din),
//            active colours (fg_color, bg_color), busy, err_overrun
// slave  = controller side, master = side driving SPI/timing and observing.
interface sprite_load_ctrl_if;
  import sprite_pkg::*;

  logic   spi_clk;
  logic   spi_data;
  logic   spi_sel_n;
  logic   vblank;
  logic   display_shift;
  logic   sprite_shift;
  logic   sprite_load;
  logic   sprite_din;
  color_t fg_color;
  color_t bg_color;
  logic   busy;
  logic   err_overrun;

  modport slave (
    input  spi_clk, spi_data, spi_sel_n, vblank, display_shift,
    output sprite_shift, sprite_load, sprite_din, fg_color, bg_color,
           busy, err_overrun
  );

  modport master (
    output spi_clk, spi_data, spi_sel_n, vblank, display_shift,
    input  sprite_shift, sprite_load, sprite_din, fg_color, bg_color,
           busy, err_overrun
  );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
//   push/wdata : write a byte (ignored when full)
//   pop        : advance to next byte (ignored when empty)
//   flush      : discard all contents
//   rdata      : current head byte, valid whenever empty is low
//   full/empty : occupancy flags
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // extra pointer MSB tells a full ring from an empty one
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sprite_load_ctrl.sv
// Sprite load controller: shares the sprite shift register between the
// display path and an SPI host.
//   clk, reset : pixel clock, asynchronous active-high reset
//   bus.spi_*  : SPI mode 0 slave pins (asynchronous to clk)
//   bus.vblank : vertical blanking; rising edge commits colours and starts
//                a pending bitmap drain
//   bus.display_shift : display shift request, has priority over the drain
//   bus.sprite_shift/sprite_load/sprite_din : sprite register controls
//   bus.fg_color/bg_color : active colours (double buffered)
//   bus.busy, bus.err_overrun : bitmap pending/draining, sticky reject flag
module sprite_load_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_BITS = 100,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter color_t      FG_RESET    = 6'b111111,
  parameter color_t      BG_RESET    = 6'b010101
) (
  input logic               clk,
  input logic               reset,
  sprite_load_ctrl_if.slave bus
);
  localparam int unsigned   BW           = $clog2(SPRITE_BITS);
  localparam logic [BW-1:0] LAST_BIT     = BW'(SPRITE_BITS - 1);
  localparam logic [3:0]    LAST_PAYLOAD = 4'(BITMAP_BYTES - 1);

  // ---------------- SPI front end ----------------
  logic [1:0] sck_sync, mosi_sync, sel_sync;
  logic       sck_prev, sel_prev;
  logic       sck_rise, sel_rise, sel_low;
  byte_t      spi_byte;
  logic [2:0] bit_idx;
  logic       byte_stb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      sel_sync  <= '1;
      sck_prev  <= 1'b0;
      sel_prev  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], bus.spi_clk};
      mosi_sync <= {mosi_sync[0], bus.spi_data};
      sel_sync  <= {sel_sync[0], bus.spi_sel_n};
      sck_prev  <= sck_sync[1];
      sel_prev  <= sel_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sel_rise = sel_sync[1] & ~sel_prev;
  assign sel_low  = ~sel_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_byte <= '0;
      bit_idx  <= '0;
      byte_stb <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if (!sel_low) begin
        bit_idx <= '0;
      end else if (sck_rise) begin
        spi_byte <= {spi_byte[6:0], mosi_sync[1]};
        bit_idx  <= bit_idx + 1'b1;
        byte_stb <= (bit_idx == 3'd7);
      end
    end
  end

  // ---------------- command decode ----------------
  state_t     state, state_n;
  logic       have_cmd, bm_accept, bitmap_ready, err_q, busy;
  byte_t      cmd;
  logic [3:0] pay_cnt;
  logic       payload_stb, fifo_push, fifo_pop, fifo_flush, bm_done;
  logic       fg_wr, bg_wr, drain_done, drain_step;
  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty;

  assign busy        = bitmap_ready || (state != IDLE);
  assign payload_stb = byte_stb && have_cmd;
  assign fifo_push   = payload_stb && (cmd == CMD_BITMAP) && bm_accept;
  assign bm_done     = fifo_push && (pay_cnt == LAST_PAYLOAD);
  // a 13th byte landing together with sel rising still completes the bitmap
  assign fifo_flush  = sel_rise && bm_accept && !bm_done;
  assign fg_wr       = payload_stb && (cmd == CMD_FG) && (pay_cnt == '0);
  assign bg_wr       = payload_stb && (cmd == CMD_BG) && (pay_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_cmd     <= 1'b0;
      cmd          <= '0;
      pay_cnt      <= '0;
      bm_accept    <= 1'b0;
      bitmap_ready <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (drain_done) bitmap_ready <= 1'b0;
      if (byte_stb && !have_cmd) begin
        have_cmd <= 1'b1;
        cmd      <= spi_byte;
        pay_cnt  <= '0;
        if (spi_byte == CMD_BITMAP) begin
          if (busy) err_q     <= 1'b1;
          else      bm_accept <= 1'b1;
        end
        if (spi_byte == CMD_CLR) err_q <= 1'b0;
      end else if (payload_stb) begin
        // saturate so surplus bytes never alias back onto payload slot 0
        if (pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
        if (bm_done) begin
          bitmap_ready <= 1'b1;
          bm_accept    <= 1'b0;
        end
      end
      if (sel_rise) begin
        have_cmd  <= 1'b0;
        bm_accept <= 1'b0;
      end
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (spi_byte),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- colour double buffer ----------------
  logic   vb_q, vb_rise;
  color_t fg_shadow, bg_shadow, fg_q, bg_q;
  logic   fg_dirty, bg_dirty;

  assign vb_rise = bus.vblank & ~vb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_q      <= 1'b0;
      fg_shadow <= FG_RESET;
      bg_shadow <= BG_RESET;
      fg_q      <= FG_RESET;
      bg_q      <= BG_RESET;
      fg_dirty  <= 1'b0;
      bg_dirty  <= 1'b0;
    end else begin
      vb_q <= bus.vblank;
      if (vb_rise) begin
        if (fg_dirty) fg_q <= fg_shadow;
        if (bg_dirty) bg_q <= bg_shadow;
        fg_dirty <= 1'b0;
        bg_dirty <= 1'b0;
      end
      // a write racing the commit stays pending for the next frame
      if (fg_wr) begin
        fg_shadow <= spi_byte[5:0];
        fg_dirty  <= 1'b1;
      end
      if (bg_wr) begin
        bg_shadow <= spi_byte[5:0];
        bg_dirty  <= 1'b1;
      end
    end
  end

  // ---------------- drain FSM ----------------
  logic [BW-1:0] bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bitmap_ready) state_n = WAIT_VB;
      WAIT_VB: if (vb_rise)      state_n = DRAIN;
      DRAIN:   if (drain_done)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    drain_step       = (state == DRAIN) && !bus.display_shift;
    drain_done       = drain_step && (bit_cnt == LAST_BIT);
    // pop at each byte boundary and after the last bit (drops the pad nibble)
    fifo_pop         = drain_step && ((bit_cnt[2:0] == 3'd7) || (bit_cnt == LAST_BIT));
    bus.sprite_shift = bus.display_shift || (state == DRAIN);
    bus.sprite_load  = drain_step;
    bus.sprite_din   = drain_step ? fifo_rdata[~bit_cnt[2:0]] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               bit_cnt <= '0;
    else if (state != DRAIN || drain_done)   bit_cnt <= '0;
    else if (drain_step)                     bit_cnt <= bit_cnt + 1'b1;
  end

  assign bus.fg_color    = fg_q;
  assign bus.bg_color    = bg_q;
  assign bus.busy        = busy;
  assign bus.err_overrun = err_q;

  a_no_pop_empty:  assert property (@(posedge clk) disable iff (reset) !(fifo_pop && fifo_empty));
  a_no_push_full:  assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_sprite_load_ctrl.sv
module tb_sprite_load_ctrl;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_load_ctrl_if bus();

  sprite_load_ctrl #(
    .SPRITE_BITS (100),
    .FIFO_DEPTH  (16),
    .FG_RESET    (6'h3F),
    .BG_RESET    (6'h15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0 SPI master, 6 clk per bit
  task automatic spi_xfer(input byte_t data [$]);
    bus.spi_sel_n = 1'b0;
    repeat (4) tick();
    foreach (data[i]) begin
      for (int b = 7; b >= 0; b--) begin
        bus.spi_data = data[i][b];
        repeat (3) tick();
        bus.spi_clk = 1'b1;
        repeat (3) tick();
        bus.spi_clk = 1'b0;
      end
    end
    repeat (4) tick();
    bus.spi_sel_n = 1'b1;
    repeat (6) tick();
  endtask

  // Reference: after the vblank edge, one bitmap bit per cycle in which
  // display_shift is low, 100 bits row-major MSB-first from the sent bytes.
  // ds_mode: 0 none, 1 three fixed cycles, 2 random 1-in-4
  task automatic run_drain(input byte_t bm [$], input bit expect_load,
                           input int ds_mode, input string tag);
    int loads, load_err, shift_err, din_err;
    bit ds, active, exp_load;
    loads = 0; load_err = 0; shift_err = 0; din_err = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      bus.vblank = (k < 20);
      case (ds_mode)
        1:       ds = (k == 20 || k == 21 || k == 50);
        2:       ds = ($urandom_range(3) == 0);
        default: ds = 1'b0;
      endcase
      bus.display_shift = ds;
      @(negedge clk);
      active   = expect_load && (k >= 1) && (loads < 100);
      exp_load = active && !ds;
      if (bus.sprite_load !== exp_load)         load_err++;
      if (bus.sprite_shift !== (ds || active))  shift_err++;
      if (bus.sprite_load === 1'b1) begin
        if (loads < 100 && bus.sprite_din !== bm[loads/8][7 - loads%8]) din_err++;
        loads++;
      end
    end
    bus.display_shift = 1'b0;
    check({tag, " load_count"}, loads, expect_load ? 100 : 0);
    check({tag, " load_timing_errs"}, load_err, 0);
    check({tag, " shift_errs"}, shift_err, 0);
    check({tag, " din_errs"}, din_err, 0);
    check({tag, " busy_after"}, 32'(bus.busy), 0);
    check({tag, " fifo_empty_after"}, 32'(dut.fifo_empty), 1);
  endtask

  typedef struct {
    byte_t  cmd;
    byte_t  p0;
    byte_t  p1;
    int     npay;
    color_t fg;
    color_t bg;
  } col_vec_t;

  col_vec_t cv [7];
  byte_t    q [$];
  byte_t    bm_a [$];
  byte_t    bm_none [$];
  color_t   prev_fg, prev_bg;
  int       mirror_err, stray_load;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cv[0] = '{8'h02, 8'h2A, 8'h00, 2, 6'h2A, 6'h15};
    cv[1] = '{8'h03, 8'hC7, 8'h00, 1, 6'h2A, 6'h07};
    cv[2] = '{8'h09, 8'h11, 8'h22, 2, 6'h2A, 6'h07};
    cv[3] = '{8'h02, 8'h15, 8'h00, 1, 6'h15, 6'h07};
    cv[4] = '{8'h04, 8'h33, 8'h00, 1, 6'h15, 6'h07};
    cv[5] = '{8'h03, 8'h3F, 8'h01, 2, 6'h15, 6'h3F};
    cv[6] = '{8'h02, 8'h0C, 8'h00, 1, 6'h0C, 6'h3F};

    reset = 1'b1;
    bus.spi_clk = 1'b0; bus.spi_data = 1'b0; bus.spi_sel_n = 1'b1;
    bus.vblank = 1'b0;  bus.display_shift = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst sprite_shift", 32'(bus.sprite_shift), 0);
    check("rst sprite_load",  32'(bus.sprite_load), 0);
    check("rst sprite_din",   32'(bus.sprite_din), 0);
    check("rst fg",           32'(bus.fg_color), 32'h3F);
    check("rst bg",           32'(bus.bg_color), 32'h15);
    check("rst busy",         32'(bus.busy), 0);
    check("rst err",          32'(bus.err_overrun), 0);
    tick();
    reset = 1'b0;

    // two idle frames
    for (int f = 0; f < 2; f++) begin
      mirror_err = 0; stray_load = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        bus.vblank = (k >= 20 && k < 30);
        bus.display_shift = 1'($urandom_range(1));
        @(negedge clk);
        if (bus.sprite_shift !== bus.display_shift) mirror_err++;
        if (bus.sprite_load !== 1'b0) stray_load++;
      end
      bus.display_shift = 1'b0;
      check("idle mirror_errs", mirror_err, 0);
      check("idle stray_loads", stray_load, 0);
      check("idle fg", 32'(bus.fg_color), 32'h3F);
      check("idle bg", 32'(bus.bg_color), 32'h15);
      check("idle busy", 32'(bus.busy), 0);
    end

    // colour command table
    prev_fg = 6'h3F; prev_bg = 6'h15;
    foreach (cv[i]) begin
      q.delete();
      q.push_back(cv[i].cmd);
      q.push_back(cv[i].p0);
      if (cv[i].npay > 1) q.push_back(cv[i].p1);
      spi_xfer(q);
      @(negedge clk);
      check($sformatf("col%0d fg_before", i), 32'(bus.fg_color), 32'(prev_fg));
      check($sformatf("col%0d bg_before", i), 32'(bus.bg_color), 32'(prev_bg));
      tick();
      bus.vblank = 1'b1;
      @(negedge clk);
      check($sformatf("col%0d fg_edge", i), 32'(bus.fg_color), 32'(prev_fg));
      @(negedge clk);
      check($sformatf("col%0d fg_after", i), 32'(bus.fg_color), 32'(cv[i].fg));
      check($sformatf("col%0d bg_after", i), 32'(bus.bg_color), 32'(cv[i].bg));
      repeat (5) tick();
      bus.vblank = 1'b0;
      repeat (5) tick();
      prev_fg = cv[i].fg; prev_bg = cv[i].bg;
    end

    // fixed 0xA5 bitmap, uninterrupted drain
    bm_a.delete();
    for (int i = 0; i < 13; i++) bm_a.push_back(8'hA5);
    q = bm_a; q.push_front(CMD_BITMAP);
    spi_xfer(q);
    @(negedge clk);
    check("a5 busy", 32'(bus.busy), 1);
    run_drain(bm_a, 1'b1, 0, "a5");

    // aborted bitmap: flushed, nothing drains
    q.delete(); q.push_back(CMD_BITMAP);
    for (int i = 0; i < 5; i++) q.push_back(byte_t'($urandom));
    spi_xfer(q);
    @(negedge clk);
    check("abort busy", 32'(bus.busy), 0);
    check("abort fifo_empty", 32'(dut.fifo_empty), 1);
    run_drain(bm_none, 1'b0, 2, "abort");

    // random bitmap after abort must not see stale bytes
    bm_a.delete();
    for (int i = 0; i < 13; i++) bm_a.push_back(byte_t'($urandom));
    q = bm_a; q.push_front(CMD_BITMAP);
    spi_xfer(q);
    run_drain(bm_a, 1'b1, 2, "post_abort");

    // overrun: second bitmap rejected, first drains intact with 3 display cycles
    bm_a.delete();
    for (int i = 0; i < 13; i++) bm_a.push_back(byte_t'($urandom));
    q = bm_a; q.push_front(CMD_BITMAP);
    spi_xfer(q);
    q.delete(); q.push_back(CMD_BITMAP);
    for (int i = 0; i < 13; i++) q.push_back(byte_t'($urandom));
    spi_xfer(q);
    @(negedge clk);
    check("ovr err", 32'(bus.err_overrun), 1);
    check("ovr busy", 32'(bus.busy), 1);
    run_drain(bm_a, 1'b1, 1, "ovr");
    check("ovr err_sticky", 32'(bus.err_overrun), 1);
    q.delete(); q.push_back(CMD_CLR);
    spi_xfer(q);
    @(negedge clk);
    check("clr err", 32'(bus.err_overrun), 0);

    // randomized rounds
    for (int r = 0; r < 2; r++) begin
      bm_a.delete();
      for (int i = 0; i < 13; i++) bm_a.push_back(byte_t'($urandom));
      q = bm_a; q.push_front(CMD_BITMAP);
      spi_xfer(q);
      run_drain(bm_a, 1'b1, 2, $sformatf("rnd%0d", r));
    end

    // reset in the middle of a drain
    bm_a.delete();
    for (int i = 0; i < 13; i++) bm_a.push_back(byte_t'($urandom));
    q = bm_a; q.push_front(CMD_BITMAP);
    spi_xfer(q);
    q.delete(); q.push_back(CMD_BITMAP);
    spi_xfer(q);
    tick();
    bus.vblank = 1'b1;
    repeat (30) tick();
    bus.vblank = 1'b0;
    @(negedge clk);
    check("mid load", 32'(bus.sprite_load), 1);
    check("mid err", 32'(bus.err_overrun), 1);
    #1 reset = 1'b1;
    #1;
    check("mrst sprite_shift", 32'(bus.sprite_shift), 0);
    check("mrst sprite_load",  32'(bus.sprite_load), 0);
    check("mrst sprite_din",   32'(bus.sprite_din), 0);
    check("mrst fg",           32'(bus.fg_color), 32'h3F);
    check("mrst bg",           32'(bus.bg_color), 32'h15);
    check("mrst busy",         32'(bus.busy), 0);
    check("mrst err",          32'(bus.err_overrun), 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    bm_a.delete();
    for (int i = 0; i < 13; i++) bm_a.push_back(byte_t'($urandom));
    q = bm_a; q.push_front(CMD_BITMAP);
    spi_xfer(q);
    run_drain(bm_a, 1'b1, 2, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
